// File: rtl/mb_reset_ctl.sv
// rtl/mb_reset_ctl.sv - DTR/button reset pulse generator with lockout and UART activity LED
module mb_reset_ctl #(
  parameter int CW              = 16,
  parameter int PULSE_CYCLES    = 1000,
  parameter int HOLDOFF_CYCLES  = 4000,
  parameter int DEBOUNCE_CYCLES = 256,
  parameter int LED_CYCLES      = 2048
) (
  input  logic pG0,
  input  logic pRST,
  input  logic dtr_n,
  input  logic btn_n,
  input  logic ftdi_rxd,
  input  logic ftdi_txd,
  output logic mb_rst_n,
  output logic act_led,
  output logic busy
);

  localparam logic [CW-1:0] PULSE_LOAD   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLDOFF_LOAD = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [CW-1:0] DB_STABLE    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LED_LOAD     = CW'(LED_CYCLES);

  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;

  logic [3:0]    raw, s1, s2, hist;
  logic [2:0]    prime;
  logic          armed;
  logic          dtr_trig, btn_trig, uart_edge;
  logic [CW-1:0] db_cnt;
  logic          btn_db, btn_db_prev, btn_stable;
  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [CW-1:0] led_cnt, led_next;

  assign raw = {ftdi_txd, ftdi_rxd, btn_n, dtr_n};

  // Edge detectors stay disarmed until the pipeline has been refilled from the
  // pins, so a line already held low across reset is seen as a level.
  always_ff @(posedge pG0 or posedge pRST) begin
    if (pRST) begin
      s1    <= '1;
      s2    <= '1;
      hist  <= '1;
      prime <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      hist  <= s2;
      prime <= {prime[1:0], 1'b1};
    end
  end

  assign armed     = prime[2];
  assign dtr_trig  = armed & hist[0] & ~s2[0];
  assign uart_edge = armed & ((s2[2] ^ hist[2]) | (s2[3] ^ hist[3]));

  assign btn_stable = (s2[1] == hist[1]);

  always_ff @(posedge pG0 or posedge pRST) begin
    if (pRST) begin
      db_cnt      <= '0;
      btn_db      <= 1'b1;
      btn_db_prev <= 1'b1;
    end else begin
      btn_db_prev <= btn_db;
      if (!btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt != DB_STABLE) begin
        db_cnt <= db_cnt + 1'b1;
      end else begin
        btn_db <= s2[1];
      end
    end
  end

  assign btn_trig = btn_db_prev & ~btn_db;

  always_ff @(posedge pG0 or posedge pRST) begin
    if (pRST) begin
      state    <= IDLE;
      cnt      <= '0;
      mb_rst_n <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      mb_rst_n <= (state_next != PULSE);
      busy     <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (dtr_trig || btn_trig) begin
          state_next = PULSE;
          cnt_next   = PULSE_LOAD;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_next = HOLDOFF;
          cnt_next   = HOLDOFF_LOAD;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    led_next = led_cnt;
    if (uart_edge) begin
      led_next = LED_LOAD;
    end else if (led_cnt != '0) begin
      led_next = led_cnt - 1'b1;
    end
  end

  always_ff @(posedge pG0 or posedge pRST) begin
    if (pRST) begin
      led_cnt <= '0;
      act_led <= 1'b0;
    end else begin
      led_cnt <= led_next;
      act_led <= (led_next != '0);
    end
  end

endmodule
